// File: rtl/dmem_resp.sv
// Data memory responder for RV32I loads and stores.
// A request is accepted in IDLE and its fields are registered. The access runs
// LATENCY cycles later, and the response is then held in RESP until the
// initiator consumes it. Misaligned, illegal or out-of-range requests leave
// memory untouched and respond with rsp_err set and zero data.
module dmem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          access_err;
  logic          do_access;
  logic [31:0]   cur_word;
  logic [31:0]   byte_shift;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign word_idx  = r_addr[AW+1:2];
  assign in_range  = (r_addr[31:2] < 30'(DEPTH));
  assign do_access = (state == WAIT) && (cnt == 4'd0);
  assign cur_word  = mem[word_idx];
  assign req_ready = (state == IDLE) && !reset;

  // Classify the registered request: alignment, legal funct3 and address range
  always_comb begin
    access_err = 1'b0;
    if (r_we) begin
      case (r_funct3)
        3'b000:  access_err = 1'b0;
        3'b001:  access_err = r_addr[0];
        3'b010:  access_err = |r_addr[1:0];
        default: access_err = 1'b1;
      endcase
    end else begin
      case (r_funct3)
        3'b000, 3'b100: access_err = 1'b0;
        3'b001, 3'b101: access_err = r_addr[0];
        3'b010:         access_err = |r_addr[1:0];
        default:        access_err = 1'b1;
      endcase
    end
    if (!in_range) begin
      access_err = 1'b1;
    end
  end

  // Pick the addressed lane out of the stored word and extend it to 32 bits
  always_comb begin
    byte_shift = cur_word >> {r_addr[1:0], 3'b000};
    byte_sel   = byte_shift[7:0];
    half_sel   = r_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (r_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      3'b010:  load_data = cur_word;
      default: load_data = 32'd0;
    endcase
  end

  // Merge store data into the current word, keeping the lanes not written
  always_comb begin
    store_word = cur_word;
    case (r_funct3)
      3'b000:  store_word[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      3'b001:  store_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      3'b010:  store_word = r_wdata;
      default: store_word = cur_word;
    endcase
  end

  // Commit a legal store when the wait expires; reset never clears storage
  always_ff @(posedge clk) begin
    if (!reset && do_access && r_we && !access_err) begin
      mem[word_idx] <= store_word;
    end
  end

  // Request/response state machine with registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            cnt      <= 4'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= access_err;
            rsp_rdata <= (r_we || access_err) ? 32'd0 : load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed load/store cases, error cases,
// back-pressure, reset in WAIT and RESP, then random traffic against a
// byte-array reference memory.
module tb_dmem_resp;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mbytes [DEPTH*4];

  dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    if ((addr >> 2) >= DEPTH) return 1'b1;
    if (we) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
      return 1'b1;
    end
    return (addr % access_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    logic [31:0] val;
    size = access_size(f3);
    val  = 32'd0;
    for (int i = 0; i < size; i++) val = val | (32'(mbytes[addr + i]) << (8 * i));
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
    return val;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < access_size(f3); i++) mbytes[addr + i] = wdata[8*i +: 8];
  endtask

  task automatic scramble_inputs();
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One full transaction: issue, measure latency, hold the response, consume it
  task automatic apply_stimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold, input string tag,
                                output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          n;
    exp_err   = model_err(we, f3, addr);
    exp_rdata = (we || exp_err) ? 32'd0 : model_load(f3, addr);
    if (we && !exp_err) model_store(f3, addr, wdata);

    @(negedge clk);
    check_output({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (rsp_valid) break;
    end
    check_output({tag, " latency"}, 32'(n), 32'(LAT));
    check_output({tag, " rdata"}, rsp_rdata, exp_rdata);
    check_output({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    got = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      scramble_inputs();
      @(posedge clk);
      #1;
      check_output({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check_output({tag, " hold rdata"}, rsp_rdata, exp_rdata);
      check_output({tag, " hold err"}, 32'(rsp_err), 32'(exp_err));
      check_output({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_output({tag, " released valid"}, 32'(rsp_valid), 32'd0);
    check_output({tag, " released req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Directed and random sequence
  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          we;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("reset req_ready", 32'(req_ready), 32'd0);
      check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("reset rsp_rdata", rsp_rdata, 32'd0);
      check_output("reset rsp_err", 32'(rsp_err), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int w = 0; w < 32; w++) apply_stimulus(1'b1, 3'b010, 32'(w * 4), $urandom, 0, "init", got);

    apply_stimulus(1'b1, 3'b010, 32'h64, 32'h80000019, 0, "sw 64", got);
    apply_stimulus(1'b0, 3'b010, 32'h64, 32'h0, 0, "lw 64", got);
    check_output("lw 64 const", got, 32'h80000019);
    apply_stimulus(1'b0, 3'b000, 32'h67, 32'h0, 0, "lb 67", got);
    check_output("lb 67 const", got, 32'hFFFFFF80);
    apply_stimulus(1'b0, 3'b100, 32'h67, 32'h0, 0, "lbu 67", got);
    check_output("lbu 67 const", got, 32'h00000080);
    apply_stimulus(1'b0, 3'b001, 32'h66, 32'h0, 0, "lh 66", got);
    check_output("lh 66 const", got, 32'hFFFF8000);
    apply_stimulus(1'b0, 3'b101, 32'h64, 32'h0, 0, "lhu 64", got);
    check_output("lhu 64 const", got, 32'h00000019);

    apply_stimulus(1'b1, 3'b010, 32'h64, 32'h11223344, 0, "sw 64b", got);
    apply_stimulus(1'b1, 3'b000, 32'h65, 32'h000000AB, 0, "sb 65", got);
    apply_stimulus(1'b0, 3'b010, 32'h64, 32'h0, 0, "lw after sb", got);
    check_output("lw after sb const", got, 32'h1122AB44);
    apply_stimulus(1'b1, 3'b001, 32'h66, 32'h0000BEEF, 0, "sh 66", got);
    apply_stimulus(1'b0, 3'b010, 32'h64, 32'h0, 0, "lw after sh", got);
    check_output("lw after sh const", got, 32'hBEEFAB44);

    apply_stimulus(1'b0, 3'b010, 32'h60, 32'h0, 0, "lw 60 before", got);
    apply_stimulus(1'b1, 3'b010, 32'h62, 32'hDEADBEEF, 0, "sw 62 misaligned", got);
    apply_stimulus(1'b1, 3'b011, 32'h60, 32'hDEADBEEF, 0, "store f3 011", got);
    apply_stimulus(1'b0, 3'b001, 32'h65, 32'h0, 0, "lh 65 misaligned", got);
    apply_stimulus(1'b0, 3'b011, 32'h64, 32'h0, 0, "load f3 011", got);
    apply_stimulus(1'b0, 3'b010, 32'h400, 32'h0, 0, "lw 400 range", got);
    apply_stimulus(1'b1, 3'b010, 32'h400, 32'h12345678, 0, "sw 400 range", got);
    apply_stimulus(1'b0, 3'b010, 32'h60, 32'h0, 0, "lw 60 after", got);
    apply_stimulus(1'b0, 3'b010, 32'h64, 32'h0, 0, "lw 64 after err", got);
    check_output("lw 64 after err const", got, 32'hBEEFAB44);

    apply_stimulus(1'b0, 3'b010, 32'h64, 32'h0, 5, "backpressure", got);

    // Reset while the store is waiting: no write, no response
    apply_stimulus(1'b1, 3'b010, 32'h10, 32'hCAFE0001, 0, "sw 10 prior", got);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("reset wait valid", 32'(rsp_valid), 32'd0);
      check_output("reset wait req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("post reset valid", 32'(rsp_valid), 32'd0);
    end
    apply_stimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw 10 after reset", got);
    check_output("lw 10 const", got, 32'hCAFE0001);

    // Reset while a response is pending drops it
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h64;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check_output("resp before reset", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset resp valid", 32'(rsp_valid), 32'd0);
    check_output("reset resp rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("after resp reset req_ready", 32'(req_ready), 32'd1);

    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 127));
      apply_stimulus(we, f3, addr, $urandom, $urandom_range(0, 2), "random", got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
